sevenseg_top: RTL and testbench
===============================

# sevenseg_top

Memory-mapped eight-digit seven-segment display peripheral on the MIPS processor's peripheral bus, next to the factorial peripheral. Software reads a result (such as n!) from the factorial peripheral and writes it here. This block converts the 32-bit binary value to decimal with an iterative double-dabble engine (one bit per cycle) and time-multiplexes the digits onto a common-anode display. It has the same four-word register window and combinational read-back as the other peripherals.

## Interface

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit; legal values ≥ 1.

Ports:
- clk  in  1  system clock; one clock domain, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a  in  2  word address in the peripheral window.
- we  in  1  write enable, already qualified by the system decoder for this window.
- wd  in  32  write data.
- rd  out  32  read data, combinational from `a`.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit anodes, active-low one-hot; an[0] is the rightmost digit.

## Operation

Register map:
- a=0 VALUE (RW, 32b): binary value. A write loads VALUE and starts a conversion.
- a=1 CTRL (RW):
  - bit0 EN: display on.
  - bit1 HEX: show VALUE as 8 hex nibbles instead of decimal.
  - rd returns {30'b0, HEX, EN}.
- a=2 STATUS (RO): {30'b0, OVF, BUSY}.
- a=3 BCD (RO): committed 8-digit BCD, digit 0 in bits [3:0].
- Writes to a=2 and a=3 are ignored.

Converter FSM, states IDLE and SHIFT:
- IDLE → SHIFT on a write to VALUE. Load shift_bin=wd, a 40-bit shift_bcd=0, cnt=0.
- In SHIFT, every cycle:
  - Add 3 to each BCD nibble that is ≥5.
  - Shift {shift_bcd, shift_bin} left by 1.
  - cnt++.
- When the 32nd shift completes:
  - Commit BCD ← shift_bcd[31:0].
  - OVF ← (shift_bcd[39:32] != 0), i.e. VALUE > 99,999,999.
  - Go to IDLE.
- A write to VALUE while in SHIFT restarts from the new value; the partial result is discarded.
- BCD and OVF hold their previous values until a conversion commits.
- BUSY = (state == SHIFT).

Scanner:
- A prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps, and the digit index d (3 bits, 0..7) increments, wrapping 7→0.
- EN=0: an=8'hFF and seg=7'h7F. The scanner keeps running.
- EN=1: an = ~(1<<d). Digit content:
  - HEX=1: VALUE[4d+3:4d], glyphs 0-9 and A-F; no blanking.
  - HEX=0, OVF=1: every digit shows a dash, seg=7'b0111111.
  - HEX=0, OVF=0: BCD digit d. Leading zeros are blanked (seg=7'h7F) for every d above the highest nonzero digit. Digit 0 is never blanked.
- Glyph encodings: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000, A=7'b0001000, b=7'b0000011, C=7'b1000110, d=7'b0100001, E=7'b0000110, F=7'b0001110.
- seg and an are registered. They change one cycle after d changes.

## Timing

- Reset values: VALUE=0, CTRL=0, BCD=0, OVF=0, state=IDLE, prescaler=0, d=0, an=8'hFF, seg=7'h7F, rd=VALUE word (0 at a=0).
- Reset in the middle of a conversion aborts it. BUSY=0 and BCD=0 on the next cycle.
- Conversion latency:
  - The write edge is E0. BUSY reads 1 after E0.
  - Shifts occur on E1..E32. BCD and OVF are committed at E32, and BUSY reads 0 after E32.
- rd is combinational: written values read back in the cycle after the write edge.
- While EN=1, each digit is lit for exactly REFRESH_DIV cycles. One full frame is 8×REFRESH_DIV cycles.

## Test plan

- Reset, then idle 10 cycles → an=FF, seg=7F, STATUS=0, BCD=0, all rd reads 0.
- Write VALUE=120 (5!) → BUSY=1 for exactly 32 cycles, then BCD=0x00000120 and OVF=0. With EN=1, REFRESH_DIV=2: digits 0-2 show 0,2,1; digits 3-7 are blank.
- Write VALUE=3628800 (10!) → BCD=0x03628800, OVF=0. Digit 7 is blank and digit 6 shows 3.
- Write VALUE=479001600 (12!) → OVF=1, BCD=0x79001600, all digits show a dash. Then set CTRL=3 → digits show hex 1C8CFC00, no blanking.
- Write 999 and, 10 cycles later, write 4321 → BUSY stays high until 32 cycles after the second write. Final BCD=0x00004321; 999 is never committed.
- Start a conversion of 12345, assert rst at shift 16 → BUSY=0 and BCD=0 next cycle. A new write of 7 gives BCD=0x00000007 after 32 cycles.

Source files
------------

// File: rtl/sevenseg_top_if.sv
// Peripheral bus window shared by the memory-mapped peripherals.
//   a  : word address inside the four-word window
//   we : write enable, already qualified by the system decoder
//   wd : write data
//   rd : read data, combinational from a
// master drives the address, write strobe and write data; slave returns rd.
interface sevenseg_top_if;
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output a, output we, output wd, input rd);
    modport slave  (input a, input we, input wd, output rd);
endinterface

// File: rtl/sevenseg_top.sv
// Eight-digit common-anode seven-segment display peripheral.
// A write to VALUE starts a one-bit-per-cycle double-dabble conversion to
// BCD; the scanner time-multiplexes the committed digits onto the display.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : register window (VALUE, CTRL, STATUS, BCD)
//   o_seg  : segments {g,f,e,d,c,b,a}, active-low, registered
//   o_an   : digit anodes, active-low one-hot, registered; bit 0 is rightmost
module sevenseg_top #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sevenseg_top_if.slave      bus,
    output logic [6:0]         o_seg,
    output logic [7:0]         o_an
);

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    localparam logic [31:0] LP_TERM = 32'(REFRESH_DIV - 1);

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [39:0] bcd_adjust(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int k = 0; k < 10; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Active-low glyph for one hex digit.
    function automatic logic [6:0] seg_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    state_t      r_state;
    logic [31:0] r_value;
    logic        r_en;
    logic        r_hex;
    logic [31:0] r_bcd;
    logic        r_ovf;
    logic [31:0] r_bin;
    logic [39:0] r_sbcd;
    logic [4:0]  r_cnt;
    logic [31:0] r_presc;
    logic [2:0]  r_digit;
    logic [7:0]  r_an;
    logic [6:0]  r_seg;

    logic        w_wr_value;
    logic        w_busy;
    logic [39:0] w_adj;
    logic [39:0] w_next_bcd;
    logic [31:0] w_next_bin;
    logic [4:0]  w_sel;
    logic [3:0]  w_hex_nib;
    logic [3:0]  w_bcd_nib;
    logic [31:0] w_upper;
    logic [6:0]  w_glyph;

    assign w_wr_value = bus.we && (bus.a == 2'd0);
    assign w_busy     = (r_state == ST_SHIFT);
    // One double-dabble step: adjust, then shift {bcd, bin} left by one.
    assign w_adj      = bcd_adjust(r_sbcd);
    assign w_next_bcd = {w_adj[38:0], r_bin[31]};
    assign w_next_bin = {r_bin[30:0], 1'b0};

    assign w_sel      = {r_digit, 2'b00};
    assign w_hex_nib  = r_value[w_sel +: 4];
    assign w_bcd_nib  = r_bcd[w_sel +: 4];
    // Digits at and above the current one; zero means it is a leading zero.
    assign w_upper    = r_bcd >> w_sel;

    assign o_an  = r_an;
    assign o_seg = r_seg;

    // Combinational register read-back.
    always_comb begin
        case (bus.a)
            2'd0:    bus.rd = r_value;
            2'd1:    bus.rd = {30'd0, r_hex, r_en};
            2'd2:    bus.rd = {30'd0, r_ovf, w_busy};
            2'd3:    bus.rd = r_bcd;
            default: bus.rd = 32'd0;
        endcase
    end

    // Software-writable VALUE and CTRL registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= 32'd0;
            r_en    <= 1'b0;
            r_hex   <= 1'b0;
        end else begin
            if (w_wr_value) begin
                r_value <= bus.wd;
            end
            if (bus.we && (bus.a == 2'd1)) begin
                r_en  <= bus.wd[0];
                r_hex <= bus.wd[1];
            end
        end
    end

    // Converter FSM; a VALUE write always (re)starts from the new value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_bin   <= 32'd0;
            r_sbcd  <= 40'd0;
            r_cnt   <= 5'd0;
            r_bcd   <= 32'd0;
            r_ovf   <= 1'b0;
        end else if (w_wr_value) begin
            r_state <= ST_SHIFT;
            r_bin   <= bus.wd;
            r_sbcd  <= 40'd0;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_SHIFT: begin
                    r_sbcd <= w_next_bcd;
                    r_bin  <= w_next_bin;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_bcd   <= w_next_bcd[31:0];
                        r_ovf   <= (w_next_bcd[39:32] != 8'd0);
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Digit content for the digit currently selected by the scanner.
    always_comb begin
        if (r_hex) begin
            w_glyph = seg_glyph(w_hex_nib);
        end else if (r_ovf) begin
            w_glyph = 7'b0111111;
        end else if ((r_digit != 3'd0) && (w_upper == 32'd0)) begin
            w_glyph = 7'b1111111;
        end else begin
            w_glyph = seg_glyph(w_bcd_nib);
        end
    end

    // Prescaler, digit index and registered display outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= 32'd0;
            r_digit <= 3'd0;
            r_an    <= 8'hFF;
            r_seg   <= 7'h7F;
        end else begin
            if (r_presc == LP_TERM) begin
                r_presc <= 32'd0;
                r_digit <= r_digit + 3'd1;
            end else begin
                r_presc <= r_presc + 32'd1;
            end
            if (r_en) begin
                r_an  <= ~(8'd1 << r_digit);
                r_seg <= w_glyph;
            end else begin
                r_an  <= 8'hFF;
                r_seg <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_top.sv
// Self-checking bench for sevenseg_top: conversion vectors from a table,
// expected results queued at write time and popped when BUSY falls, plus
// hand-written restart, reset-abort and ignored-write sequences.
module tb_sevenseg_top;
    localparam int RDIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic [7:0] an;

    sevenseg_top_if bus ();

    sevenseg_top #(.REFRESH_DIV(RDIV)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus),
        .o_seg (seg),
        .o_an  (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    int n_vec = 0;
    int n_err = 0;

    // Bench-side model of the peripheral state.
    logic        en_m = 1'b0;
    logic        hex_m = 1'b0;
    logic [31:0] value_m = 32'd0;
    logic [31:0] bcd_m = 32'd0;
    logic        ovf_m = 1'b0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        bus.a = a;
        #1;
        v = bus.rd;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus.a  = a;
        bus.wd = d;
        bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
        bus.a  = 2'd0;
    endtask

    function automatic logic [6:0] exp_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;  default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        logic [31:0] upper;
        upper = bcd_m >> (4 * d);
        if (hex_m) return exp_glyph(value_m[4*d +: 4]);
        if (ovf_m) return 7'b0111111;
        if ((d != 0) && (upper == 32'd0)) return 7'h7F;
        return exp_glyph(bcd_m[4*d +: 4]);
    endfunction

    // Watch one full frame and compare every digit against the model.
    task automatic check_display(input string tag);
        int         lit[8];
        logic [6:0] cap[8];
        int         bad;
        bit         found;
        bit         scan_ok;
        repeat (4) tick();
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            lit[k] = 0;
            cap[k] = 7'h7F;
        end
        for (int c = 0; c < 8 * RDIV; c++) begin
            tick();
            if (!en_m) begin
                if ((an !== 8'hFF) || (seg !== 7'h7F)) bad++;
            end else begin
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (an === ~(8'd1 << k)) begin
                        lit[k]++;
                        cap[k] = seg;
                        found = 1'b1;
                    end
                end
                if (!found) bad++;
            end
        end
        if (!en_m) begin
            check($sformatf("%s_off", tag), 40'(bad), 40'd0);
        end else begin
            scan_ok = (bad == 0);
            for (int k = 0; k < 8; k++) if (lit[k] != RDIV) scan_ok = 1'b0;
            check($sformatf("%s_scan", tag), 40'(scan_ok), 40'd1);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("%s_digit%0d", tag, k), 40'(cap[k]), 40'(exp_seg(k)));
            end
        end
    endtask

    // Compare the committed result against the oldest queued expectation.
    task automatic pop_compare(input string tag);
        exp_t        e;
        logic [31:0] v;
        logic [31:0] st;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 40'd1, 40'd0);
        end else begin
            e = sb_q.pop_front();
            rd_reg(2'd3, v);
            rd_reg(2'd2, st);
            check({tag, "_bcd"}, 40'(v), 40'(e.bcd));
            check({tag, "_ovf"}, 40'(st[1]), 40'(e.ovf));
            bcd_m = e.bcd;
            ovf_m = e.ovf;
        end
    endtask

    // Wait (bounded) for BUSY to drop; returns the number of busy cycles after E0.
    task automatic wait_idle(output int cycles);
        logic [31:0] st;
        cycles = 0;
        rd_reg(2'd2, st);
        while (st[0] && (cycles < 200)) begin
            tick();
            cycles++;
            rd_reg(2'd2, st);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] value, input logic [31:0] bcd, input logic ovf);
        int          cyc;
        logic [31:0] st;
        sb_q.push_back('{bcd, ovf});
        do_write(2'd0, value);
        value_m = value;
        rd_reg(2'd2, st);
        check({tag, "_busy_e0"}, 40'(st[0]), 40'd1);
        wait_idle(cyc);
        check({tag, "_latency"}, 40'(cyc), 40'd32);
        pop_compare(tag);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] st;
        int          cyc;
        int          hi;

        vecs[0] = '{32'd120,        32'h00000120, 1'b0};
        vecs[1] = '{32'd3628800,    32'h03628800, 1'b0};
        vecs[2] = '{32'd479001600,  32'h79001600, 1'b1};
        vecs[3] = '{32'd0,          32'h00000000, 1'b0};
        vecs[4] = '{32'd99999999,   32'h99999999, 1'b0};
        vecs[5] = '{32'd100000000,  32'h00000000, 1'b1};
        vecs[6] = '{32'hFFFFFFFF,   32'h94967295, 1'b1};
        vecs[7] = '{32'd10203,      32'h00010203, 1'b0};
        vecs[8] = '{32'd7,          32'h00000007, 1'b0};

        bus.a  = 2'd0;
        bus.we = 1'b0;
        bus.wd = 32'd0;
        rst    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Reset state.
        check("reset_an", 40'(an), 40'hFF);
        check("reset_seg", 40'(seg), 40'h7F);
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            check($sformatf("reset_rd%0d", a), 40'(v), 40'd0);
        end
        check_display("reset");

        do_write(2'd1, 32'd1);
        en_m = 1'b1;
        rd_reg(2'd1, v);
        check("ctrl_en_rd", 40'(v), 40'd1);

        for (int i = 0; i < 9; i++) begin
            convert($sformatf("vec%0d", i), vecs[i].value, vecs[i].bcd, vecs[i].ovf);
            rd_reg(2'd0, v);
            check($sformatf("vec%0d_value_rd", i), 40'(v), 40'(vecs[i].value));
            check_display($sformatf("vec%0d", i));
            if (vecs[i].value == 32'd479001600) begin
                do_write(2'd1, 32'd3);
                hex_m = 1'b1;
                rd_reg(2'd1, v);
                check("ctrl_hex_rd", 40'(v), 40'd3);
                check_display("hex");
                do_write(2'd1, 32'd1);
                hex_m = 1'b0;
            end
        end

        // STATUS and BCD are read-only.
        do_write(2'd3, 32'hFFFFFFFF);
        do_write(2'd2, 32'hFFFFFFFF);
        rd_reg(2'd3, v);
        check("ro_bcd", 40'(v), 40'(bcd_m));
        rd_reg(2'd2, st);
        check("ro_status", 40'(st), 40'({30'd0, ovf_m, 1'b0}));

        // Restart: 999 is overwritten by 4321 before it can commit.
        sb_q.push_back('{32'h00004321, 1'b0});
        do_write(2'd0, 32'd999);
        hi = 0;
        for (int c = 0; c < 9; c++) begin
            rd_reg(2'd2, st);
            if (st[0]) hi++;
            tick();
        end
        check("restart_busy_hold", 40'(hi), 40'd9);
        rd_reg(2'd3, v);
        check("restart_bcd_held", 40'(v), 40'(bcd_m));
        do_write(2'd0, 32'd4321);
        value_m = 32'd4321;
        wait_idle(cyc);
        check("restart_latency", 40'(cyc), 40'd32);
        pop_compare("restart");
        check_display("restart");

        // Reset in the middle of a conversion aborts it.
        do_write(2'd0, 32'd12345);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rd_reg(2'd2, st);
        check("abort_status", 40'(st), 40'd0);
        rd_reg(2'd3, v);
        check("abort_bcd", 40'(v), 40'd0);
        check("abort_an", 40'(an), 40'hFF);
        rst = 1'b0;
        en_m = 1'b0; hex_m = 1'b0; value_m = 32'd0; bcd_m = 32'd0; ovf_m = 1'b0;
        tick();

        convert("after_abort", 32'd7, 32'h00000007, 1'b0);
        check_display("after_abort");
        do_write(2'd1, 32'd1);
        en_m = 1'b1;
        check_display("after_abort_en");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end
endmodule
